// File: rtl/fdc_datasep.sv
// Floppy read-data separator: glitch filter, reshaped read pulse, and a digital PLL
// that recovers vg_rclk and reports lock and out-of-window error counts.
`timescale 1ns/1ps
module fdc_datasep #(
    parameter int CLK_DIV_DD = 56,
    parameter int FILT_LEN   = 4,
    parameter int RAWR_LEN   = 4,
    parameter int GAIN_SHIFT = 1,
    parameter int LOCK_WIN   = 4,
    parameter int LOCK_CNT   = 8,
    parameter int TIMEOUT_HP = 8
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_hd,
    input  logic       i_rdat_n,
    input  logic       i_err_clr,
    output logic       o_vg_rclk,
    output logic       o_vg_rawr,
    output logic       o_locked,
    output logic [7:0] o_err_cnt
);
    localparam logic signed [7:0] C_WIN  = 8'(LOCK_WIN);
    localparam logic        [7:0] C_LOCK = 8'(LOCK_CNT);
    localparam logic        [7:0] C_TO   = 8'(TIMEOUT_HP);

    logic [FILT_LEN-1:0] r_filt_sr;
    logic                r_filt;
    logic                r_filt_d;
    logic [3:0]          r_rawr_cnt;
    logic                r_hd;
    logic [6:0]          r_phase;
    logic                r_rclk;
    logic [7:0]          r_lock_cnt;
    logic [7:0]          r_to_cnt;
    logic                r_locked;
    logic [7:0]          r_err_cnt;

    logic                w_pulse;
    logic                w_oow;
    logic [6:0]          w_half;
    logic [6:0]          w_half_m1;
    logic                w_wrap;
    logic [6:0]          w_phase_eff;
    logic signed [7:0]   w_err;
    logic signed [7:0]   w_corr;
    logic signed [8:0]   w_sum;
    logic                w_in_win;
    logic [6:0]          w_phase_n;
    logic [7:0]          w_lock_n;
    logic [7:0]          w_to_n;

    // The shift register itself absorbs the asynchronous rdat_n; the level only
    // moves once FILT_LEN consecutive samples agree.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_sr <= '1;
            r_filt    <= 1'b1;
            r_filt_d  <= 1'b1;
        end else begin
            r_filt_sr <= {r_filt_sr[FILT_LEN-2:0], i_rdat_n};
            if (&r_filt_sr)
                r_filt <= 1'b1;
            else if (~|r_filt_sr)
                r_filt <= 1'b0;
            r_filt_d <= r_filt;
        end
    end

    assign w_pulse = r_filt_d & ~r_filt & i_enable;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_half      = r_hd ? 7'(CLK_DIV_DD / 2) : 7'(CLK_DIV_DD);
        w_half_m1   = w_half - 7'd1;
        w_wrap      = (r_phase >= w_half_m1);
        w_phase_eff = w_wrap ? w_half_m1 : r_phase;
        w_err       = $signed({1'b0, w_half >> 1}) - 8'sd1 - $signed({1'b0, w_phase_eff});
        w_corr      = w_err >>> GAIN_SHIFT;
        w_sum       = $signed({2'b00, r_phase}) + 9'sd1 + $signed({w_corr[7], w_corr});
        w_in_win    = (w_err <= C_WIN) && (w_err >= -C_WIN);
        w_oow       = w_pulse & ~w_in_win;

        w_phase_n = r_phase + 7'd1;
        if (w_wrap)
            w_phase_n = 7'd0;
        else if (w_pulse) begin
            if (w_sum < 9'sd0)
                w_phase_n = 7'd0;
            else if (w_sum > $signed({2'b00, w_half_m1}))
                w_phase_n = w_half_m1;
            else
                w_phase_n = w_sum[6:0];
        end

        w_to_n = r_to_cnt;
        if (w_pulse)
            w_to_n = 8'd0;
        else if (w_wrap && (r_to_cnt < C_TO))
            w_to_n = r_to_cnt + 8'd1;

        w_lock_n = r_lock_cnt;
        if (w_pulse)
            w_lock_n = w_in_win ? ((r_lock_cnt < C_LOCK) ? r_lock_cnt + 8'd1 : r_lock_cnt) : 8'd0;
        if (w_to_n >= C_TO)
            w_lock_n = 8'd0;
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hd       <= 1'b0;
            r_phase    <= 7'd0;
            r_rclk     <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_to_cnt   <= 8'd0;
            r_locked   <= 1'b0;
            r_rawr_cnt <= 4'd0;
        end else begin
            r_hd <= i_hd;
            if (!i_enable) begin
                r_phase    <= 7'd0;
                r_rclk     <= 1'b0;
                r_lock_cnt <= 8'd0;
                r_to_cnt   <= 8'd0;
                r_locked   <= 1'b0;
                r_rawr_cnt <= 4'd0;
            end else begin
                if (w_pulse)
                    r_rawr_cnt <= 4'(RAWR_LEN);
                else if (r_rawr_cnt != 4'd0)
                    r_rawr_cnt <= r_rawr_cnt - 4'd1;
                // A rate change restarts tracking but keeps vg_rclk's current level.
                if (i_hd != r_hd) begin
                    r_phase    <= 7'd0;
                    r_lock_cnt <= 8'd0;
                    r_to_cnt   <= 8'd0;
                    r_locked   <= 1'b0;
                end else begin
                    r_phase    <= w_phase_n;
                    r_rclk     <= r_rclk ^ w_wrap;
                    r_lock_cnt <= w_lock_n;
                    r_to_cnt   <= w_to_n;
                    r_locked   <= (w_lock_n == C_LOCK);
                end
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= 8'd0;
        else if (i_err_clr)
            r_err_cnt <= {7'd0, w_oow};
        else if (w_oow && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_vg_rclk = r_rclk;
    assign o_vg_rawr = (r_rawr_cnt == 4'd0);
    assign o_locked  = r_locked;
    assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_fdc_datasep.sv
// Directed-sequence bench for fdc_datasep; pulse timing is placed relative to observed
// vg_rclk toggles and corrections are inferred from the time to the next toggle.
`timescale 1ns/1ps
module tb_fdc_datasep;
    localparam int HALF_DD    = 56;
    localparam int FILT_LEN   = 4;
    localparam int RAWR_LEN   = 4;
    localparam int GAIN_SHIFT = 1;
    localparam int LOCK_WIN   = 4;
    localparam int LOCK_CNT   = 8;
    localparam int TIMEOUT_HP = 8;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       hd = 1'b0;
    logic       rdat_n = 1'b1;
    logic       err_clr = 1'b0;
    logic       vg_rclk;
    logic       vg_rawr;
    logic       locked;
    logic [7:0] err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: half-period length, lock progress, error tally.
    int m_half   = HALF_DD;
    int m_lock   = 0;
    int m_err    = 0;
    int m_locked = 0;

    always #5 fclk = ~fclk;

    fdc_datasep #(
        .CLK_DIV_DD(HALF_DD), .FILT_LEN(FILT_LEN), .RAWR_LEN(RAWR_LEN),
        .GAIN_SHIFT(GAIN_SHIFT), .LOCK_WIN(LOCK_WIN), .LOCK_CNT(LOCK_CNT),
        .TIMEOUT_HP(TIMEOUT_HP)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .i_enable(enable), .i_hd(hd),
        .i_rdat_n(rdat_n), .i_err_clr(err_clr), .o_vg_rclk(vg_rclk),
        .o_vg_rawr(vg_rawr), .o_locked(locked), .o_err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Ticks until vg_rclk changes level, bounded.
    task automatic wait_toggle(output int ticks);
        logic prev;
        prev  = vg_rclk;
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (vg_rclk === prev && ticks < 400);
        check("toggle_seen", {31'd0, vg_rclk}, {31'd0, ~prev});
    endtask

    function automatic int floor_div(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int phase_after(int c, int half);
        int e, n;
        e = half / 2 - 1 - c;
        n = c + 1 + floor_div(e, 1 << GAIN_SHIFT);
        if (n < 0) n = 0;
        if (n > half - 1) n = half - 1;
        return n;
    endfunction

    // Called right after a toggle (phase 0): makes the pulse strobe land at phase c.
    task automatic pulse_at(input int c, input bit clr);
        int e, n, t;
        bit in_win;
        repeat (c - FILT_LEN - 1) tick();
        rdat_n = 1'b0;
        repeat (FILT_LEN + 1) tick();
        rdat_n = 1'b1;
        check("locked_pre", {31'd0, locked}, m_locked);
        e      = m_half / 2 - 1 - c;
        n      = phase_after(c, m_half);
        in_win = (e <= LOCK_WIN) && (e >= -LOCK_WIN);
        if (in_win) m_lock = (m_lock < LOCK_CNT) ? m_lock + 1 : m_lock;
        else        m_lock = 0;
        m_locked = (m_lock == LOCK_CNT);
        if (clr)          m_err = in_win ? 0 : 1;
        else if (!in_win) m_err = (m_err < 255) ? m_err + 1 : 255;
        err_clr = clr;
        tick();
        err_clr = 1'b0;
        check("locked_post", {31'd0, locked}, m_locked);
        check("err_cnt", {24'd0, err_cnt}, m_err);
        check("rawr_start", {31'd0, vg_rawr}, 0);
        wait_toggle(t);
        check("phase_corr", m_half - t, n);
    endtask

    initial begin
        logic [11:0] seen, want;
        int t, t2, c;

        #23;
        check("rst_rclk", {31'd0, vg_rclk}, 0);
        check("rst_rawr", {31'd0, vg_rawr}, 1);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_err", {24'd0, err_cnt}, 0);
        @(negedge fclk);
        rst_n = 1'b1;
        tick();
        enable = 1'b1;

        // Glitch shorter than the filter: no read pulse.
        rdat_n = 1'b0;
        repeat (FILT_LEN - 1) tick();
        rdat_n = 1'b1;
        seen = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen[i] = vg_rawr;
        end
        check("glitch_rawr", {20'd0, seen}, 12'hFFF);

        // Minimum valid pulse: shape and latency of vg_rawr.
        rdat_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == FILT_LEN) rdat_n = 1'b1;
            seen[i-1] = vg_rawr;
            want[i-1] = !(i >= FILT_LEN + 2 && i < FILT_LEN + 2 + RAWR_LEN);
        end
        check("rawr_shape", {20'd0, seen}, {20'd0, want});

        enable  = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("dis_err", {24'd0, err_cnt}, 0);
        check("dis_locked", {31'd0, locked}, 0);
        check("dis_rclk", {31'd0, vg_rclk}, 0);

        // Free run at DD, then HD.
        enable = 1'b1;
        wait_toggle(t);
        check("first_half_dd", t, HALF_DD);
        wait_toggle(t);
        wait_toggle(t2);
        check("period_dd", t + t2, 2 * HALF_DD);
        hd = 1'b1;
        t2 = vg_rclk;
        tick();
        check("hd_hold_rclk", {31'd0, vg_rclk}, t2);
        wait_toggle(t);
        check("hd_restart", t + 1, HALF_DD / 2 + 1);
        wait_toggle(t);
        wait_toggle(t2);
        check("period_hd", t + t2, HALF_DD);
        hd = 1'b0;
        tick();
        wait_toggle(t);
        check("dd_restart", t + 1, HALF_DD + 1);
        m_half = HALF_DD;

        // Phase correction: directed points, then random phases.
        pulse_at(20, 0);
        pulse_at(40, 0);
        repeat (10) pulse_at($urandom_range(FILT_LEN + 1, m_half - 2), 0);

        // Lock acquisition and loss.
        pulse_at(5, 0);
        repeat (LOCK_CNT) pulse_at(m_half / 2 - 1, 0);
        check("locked_after_n", {31'd0, locked}, 1);
        pulse_at(5, 0);
        check("unlock_oow", {31'd0, locked}, 0);

        // Relock at random in-window phases, then let it time out.
        repeat (LOCK_CNT) begin
            c = m_half / 2 - 1 - LOCK_WIN + $urandom_range(0, 2 * LOCK_WIN);
            pulse_at(c, 0);
        end
        check("relocked", {31'd0, locked}, 1);
        repeat (TIMEOUT_HP - 2) wait_toggle(t);
        check("still_locked", {31'd0, locked}, 1);
        wait_toggle(t);
        check("timeout_unlock", {31'd0, locked}, 0);
        m_lock   = 0;
        m_locked = 0;

        // Error counter saturation and clear, at HD for speed.
        hd = 1'b1;
        tick();
        m_half = HALF_DD / 2;
        wait_toggle(t);
        repeat (300) pulse_at(5, 0);
        check("err_sat", {24'd0, err_cnt}, 255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 0;
        check("err_clear", {24'd0, err_cnt}, 0);
        wait_toggle(t);
        pulse_at(5, 1);
        check("err_clr_and_pulse", {24'd0, err_cnt}, 1);

        // Disable: outputs forced, pulses ignored, err_cnt held.
        enable = 1'b0;
        tick();
        check("off_rclk", {31'd0, vg_rclk}, 0);
        check("off_rawr", {31'd0, vg_rawr}, 1);
        check("off_locked", {31'd0, locked}, 0);
        rdat_n = 1'b0;
        repeat (FILT_LEN + 2) tick();
        rdat_n = 1'b1;
        seen = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen[i] = vg_rawr;
        end
        check("off_rawr_idle", {20'd0, seen}, 12'hFFF);
        check("off_err_hold", {24'd0, err_cnt}, 1);

        // Relock at DD, then reset asynchronously partway through a pulse.
        enable = 1'b1;
        hd     = 1'b0;
        m_half = HALF_DD;
        m_lock = 0;
        m_locked = 0;
        tick();
        wait_toggle(t);
        repeat (LOCK_CNT) pulse_at(m_half / 2 - 1, 0);
        check("lock_before_rst", {31'd0, locked}, 1);
        rdat_n = 1'b0;
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rclk", {31'd0, vg_rclk}, 0);
        check("mid_rst_rawr", {31'd0, vg_rawr}, 1);
        check("mid_rst_locked", {31'd0, locked}, 0);
        check("mid_rst_err", {24'd0, err_cnt}, 0);
        rdat_n = 1'b1;
        repeat (3) tick();
        @(negedge fclk);
        rst_n = 1'b1;
        seen = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen[i] = vg_rawr;
        end
        check("post_rst_no_pulse", {20'd0, seen}, 12'hFFF);
        check("post_rst_err", {24'd0, err_cnt}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
